epp_slave: RTL and testbench

EPP-mode parallel-port slave front end for the pluto stepper firmware: synchronizes the host's asynchronous EPP handshakes into `clk`, generates `nWait`, maintains an auto-incrementing register address, and assembles 8-bit host writes into 16-bit register writes. On reads it latches a 32-bit word from the register file and serializes it byte-wise onto `pport_data`. It sits between the parallel-port pins and the stepgen/dout register file. The register file consumes `wr_*` and answers `rd_*`.

---
 rtl/pluto_pkg.sv | 50 +++++
 rtl/edge_sync.sv | 37 +++
 rtl/epp_slave.sv | 126 ++++++++++++
 tb/tb_epp_slave.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pluto_pkg.sv
// Shared constants and helpers for the pluto EPP front end and its register file.
package pluto_pkg;

   // Default register address width.
   localparam int AW_DEFAULT = 5;

   // Depth of the strobe synchronizer chains.
   localparam int STROBE_SYNC_DEPTH = 3;

   // Depth of the nWrite direction synchronizer.
   localparam int DIR_SYNC_DEPTH = 2;

   // Write register addresses (16-bit registers land on odd addresses).
   localparam logic [4:0] REG_VELOCITY0 = 5'd1;
   localparam logic [4:0] REG_VELOCITY1 = 5'd3;
   localparam logic [4:0] REG_VELOCITY2 = 5'd5;
   localparam logic [4:0] REG_VELOCITY3 = 5'd7;
   localparam logic [4:0] REG_DOUT      = 5'd9;
   localparam logic [4:0] REG_CONFIG    = 5'd11;

   // Read word indices (each word spans four byte addresses).
   localparam logic [2:0] RD_WORD_POS0   = 3'd0;
   localparam logic [2:0] RD_WORD_POS1   = 3'd1;
   localparam logic [2:0] RD_WORD_POS2   = 3'd2;
   localparam logic [2:0] RD_WORD_POS3   = 3'd3;
   localparam logic [2:0] RD_WORD_STATUS = 3'd4;

   // Byte lanes of a latched read word, least significant first.
   typedef enum logic [1:0] {
      LANE_B0 = 2'd0,
      LANE_B1 = 2'd1,
      LANE_B2 = 2'd2,
      LANE_B3 = 2'd3
   } byte_lane_e;

   // Pick one byte lane out of a 32-bit word.
   function automatic logic [7:0] select_byte(input logic [31:0] word, input byte_lane_e lane);
      logic [7:0] result;
      result = 8'h00;
      unique case (lane)
         LANE_B0: result = word[7:0];
         LANE_B1: result = word[15:8];
         LANE_B2: result = word[23:16];
         LANE_B3: result = word[31:24];
         default: result = 8'h00;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/edge_sync.sv
// Three-flop synchronizer for an active-high strobe, producing one-cycle
// assert and release pulses. Assert pulses are suppressed until the
// synchronizer has seen the strobe idle after reset, so a strobe already in
// flight when reset hits is treated as aborted rather than re-detected.
module edge_sync
   import pluto_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic strobe_in,
   output logic asserted,
   output logic released
);

   logic [STROBE_SYNC_DEPTH-1:0] sync_chain;
   logic [1:0]                   filled;
   logic                         armed;

   // Shift the raw strobe in and track when the chain holds real samples.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_chain <= '0;
         filled     <= '0;
         armed      <= 1'b0;
      end else begin
         sync_chain <= {sync_chain[STROBE_SYNC_DEPTH-2:0], strobe_in};
         filled     <= {filled[0], 1'b1};
         if (filled[1] && !sync_chain[1]) begin
            armed <= 1'b1;
         end
      end
   end

   assign asserted = armed && (sync_chain[2:1] == 2'b01);
   assign released = (sync_chain[2:1] == 2'b10);

endmodule

// File: rtl/epp_slave.sv
// EPP parallel-port slave: synchronizes host strobes, generates nWait,
// keeps an auto-incrementing register address, pairs byte writes into
// 16-bit register writes and serializes latched 32-bit read words.
module epp_slave
   import pluto_pkg::*;
#(
   parameter int AW       = AW_DEFAULT,
   parameter int WAIT_DLY = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          nWrite,
   input  logic          nDataStr,
   input  logic          nAddrStr,
   output logic          nWait,
   inout  wire  [7:0]    pport_data,
   output logic          wr_stb,
   output logic [AW-1:0] wr_addr,
   output logic [15:0]   wr_data,
   output logic          rd_req,
   output logic [AW-1:0] rd_addr,
   input  logic [31:0]   rd_data
);

   logic [DIR_SYNC_DEPTH-1:0] dir_sync;
   logic                      read;
   logic                      write;
   logic                      astb_assert;
   logic                      astb_release;
   logic                      dstb_assert;
   logic                      dstb_release;
   logic [WAIT_DLY-1:0]       wait_chain;
   logic                      wait_active;
   logic [AW-1:0]             addr;
   logic [7:0]                lowbyte;
   logic [31:0]               data_buf;
   logic [7:0]                byte_out;

   edge_sync u_addr_sync (
      .clk       (clk),
      .reset     (reset),
      .strobe_in (~nAddrStr),
      .asserted  (astb_assert),
      .released  (astb_release)
   );

   edge_sync u_data_sync (
      .clk       (clk),
      .reset     (reset),
      .strobe_in (~nDataStr),
      .asserted  (dstb_assert),
      .released  (dstb_release)
   );

   // Bring the host's transfer direction into the clk domain.
   always_ff @(posedge clk) begin
      if (reset) begin
         dir_sync <= '0;
      end else begin
         dir_sync <= {dir_sync[DIR_SYNC_DEPTH-2:0], nWrite};
      end
   end

   assign read  = dir_sync[DIR_SYNC_DEPTH-1];
   assign write = ~read;

   // Delay line from any strobe to the wait handshake back to the host.
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_chain <= '0;
      end else begin
         wait_chain <= {wait_chain[WAIT_DLY-2:0], (~nAddrStr) | (~nDataStr)};
      end
   end

   assign wait_active = wait_chain[WAIT_DLY-1];
   assign nWait       = ~wait_active;

   // Address register: an address strobe load beats the post-data increment.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr <= '0;
      end else if (astb_assert && write) begin
         addr <= pport_data[AW-1:0];
      end else if (dstb_release) begin
         addr <= addr + 1'b1;
      end
   end

   // Pair host byte writes into register writes and fetch read words.
   always_ff @(posedge clk) begin
      if (reset) begin
         lowbyte  <= '0;
         data_buf <= '0;
         wr_stb   <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         rd_req   <= 1'b0;
         rd_addr  <= '0;
      end else begin
         wr_stb <= 1'b0;
         rd_req <= 1'b0;
         if (dstb_assert && write) begin
            if (!addr[0]) begin
               lowbyte <= pport_data;
            end else begin
               wr_stb  <= 1'b1;
               wr_addr <= addr;
               wr_data <= {pport_data, lowbyte};
            end
         end
         if (dstb_assert && read && (addr[1:0] == 2'b00)) begin
            rd_req   <= 1'b1;
            rd_addr  <= addr;
            data_buf <= rd_data;
         end
      end
   end

   assign byte_out   = select_byte(data_buf, byte_lane_e'(addr[1:0]));
   assign pport_data = (read && wait_active) ? byte_out : 8'bzzzz_zzzz;

   logic unused_ok;
   assign unused_ok = astb_release;

endmodule

// File: tb/tb_epp_slave.sv
// Self-checking bench for epp_slave: a host model drives EPP cycles and
// queues the register-file events it expects; a monitor checks them.
module tb_epp_slave;

   logic        clk;
   logic        reset;
   logic        nWrite;
   logic        nDataStr;
   logic        nAddrStr;
   logic        nWait;
   wire  [7:0]  pport_data;
   logic        wr_stb;
   logic [4:0]  wr_addr;
   logic [15:0] wr_data;
   logic        rd_req;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;

   logic [7:0]  host_data;
   logic        host_drive;

   int checks;
   int failures;

   typedef struct {
      logic        is_rd;
      logic [4:0]  a;
      logic [15:0] d;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   epp_slave #(.AW(5), .WAIT_DLY(3)) dut (
      .clk        (clk),
      .reset      (reset),
      .nWrite     (nWrite),
      .nDataStr   (nDataStr),
      .nAddrStr   (nAddrStr),
      .nWait      (nWait),
      .pport_data (pport_data),
      .wr_stb     (wr_stb),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_req     (rd_req),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data)
   );

   assign pport_data = host_drive ? host_data : 8'bzzzz_zzzz;

   for (genvar i = 0; i < 8; i++) begin : g_pull
      pullup (pport_data[i]);
   end

   // Free-running 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the host model wedges.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, wanted completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, actual, expected);
      end
   endtask

   task automatic pushWr(input logic [4:0] a, input logic [15:0] d);
      exp_t e;
      e.is_rd = 1'b0;
      e.a     = a;
      e.d     = d;
      exp_q.push_back(e);
   endtask

   task automatic pushRd(input logic [4:0] a);
      exp_t e;
      e.is_rd = 1'b1;
      e.a     = a;
      e.d     = 16'h0000;
      exp_q.push_back(e);
   endtask

   // Wait at falling edges until nWait reaches the given level, bounded.
   task automatic waitNWait(input logic level, input string name);
      int n;
      n = 0;
      while (nWait !== level && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (nWait !== level) begin
         checks++;
         failures++;
         $display("[TB] FAIL %s: nWait stuck at %b, wanted %b", name, nWait, level);
      end
   endtask

   // One complete EPP host cycle (address write, data write or data read).
   task automatic applyStimulus(input bit is_addr, input bit is_read, input logic [7:0] value,
                                input bit check_byte, input logic [7:0] exp_byte);
      @(negedge clk);
      nWrite     = is_read;
      host_data  = value;
      host_drive = !is_read;
      @(negedge clk);
      @(negedge clk);
      if (is_addr) nAddrStr = 1'b0;
      else         nDataStr = 1'b0;
      waitNWait(1'b0, "strobe ack");
      if (is_read && check_byte) checkOutput("read byte", {24'h0, pport_data}, {24'h0, exp_byte});
      @(negedge clk);
      nAddrStr = 1'b1;
      nDataStr = 1'b1;
      waitNWait(1'b1, "strobe release");
      @(negedge clk);
      host_drive = 1'b0;
      nWrite     = 1'b1;
   endtask

   // Scoreboard monitor: every register-file pulse must match the queue head.
   always @(negedge clk) begin
      if (wr_stb) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected wr_stb: got addr 0x%0h data 0x%0h, wanted no event", wr_addr, wr_data);
         end else begin
            mon_e = exp_q.pop_front();
            checkOutput("wr event", {10'h0, 1'b0, wr_addr, wr_data}, {10'h0, mon_e.is_rd, mon_e.a, mon_e.d});
         end
      end
      if (rd_req) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected rd_req: got addr 0x%0h, wanted no event", rd_addr);
         end else begin
            mon_e = exp_q.pop_front();
            checkOutput("rd event", {26'h0, 1'b1, rd_addr}, {26'h0, mon_e.is_rd, mon_e.a});
         end
      end
   end

   initial begin
      int n;
      checks     = 0;
      failures   = 0;
      reset      = 1'b1;
      nWrite     = 1'b1;
      nDataStr   = 1'b1;
      nAddrStr   = 1'b1;
      host_data  = 8'h00;
      host_drive = 1'b0;
      rd_data    = 32'hDEAD_BEEF;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      checkOutput("reset nWait", {31'h0, nWait}, 32'h1);
      checkOutput("reset bus idle", {24'h0, pport_data}, 32'hFF);
      checkOutput("reset wr_stb", {31'h0, wr_stb}, 32'h0);
      checkOutput("reset rd_req", {31'h0, rd_req}, 32'h0);
      repeat (5) @(negedge clk);

      // Address then two write pairs
      applyStimulus(1, 0, 8'h00, 0, 8'h00);
      applyStimulus(0, 0, 8'h34, 0, 8'h00);
      pushWr(5'd1, 16'h1234);
      applyStimulus(0, 0, 8'h12, 0, 8'h00);
      applyStimulus(0, 0, 8'h78, 0, 8'h00);
      pushWr(5'd3, 16'h5678);
      applyStimulus(0, 0, 8'h56, 0, 8'h00);

      // Read burst of one word
      applyStimulus(1, 0, 8'h00, 0, 8'h00);
      pushRd(5'd0);
      applyStimulus(0, 1, 8'h00, 1, 8'hEF);
      applyStimulus(0, 1, 8'h00, 1, 8'hBE);
      applyStimulus(0, 1, 8'h00, 1, 8'hAD);
      applyStimulus(0, 1, 8'h00, 1, 8'hDE);

      // Wait timing on a fresh word fetch at address 4
      rd_data = 32'h0123_4567;
      pushRd(5'd4);
      @(negedge clk);
      nWrite = 1'b1;
      repeat (2) @(negedge clk);
      nDataStr = 1'b0;
      n = 0;
      while (n < 10) begin
         @(posedge clk);
         #1;
         n++;
         if (nWait == 1'b0) break;
      end
      checkOutput("nWait fall edges", n, 32'd3);
      @(negedge clk);
      checkOutput("read byte addr4", {24'h0, pport_data}, 32'h67);
      nDataStr = 1'b1;
      n = 0;
      while (n < 10) begin
         @(posedge clk);
         #1;
         n++;
         if (nWait == 1'b1) break;
      end
      checkOutput("nWait rise edges", n, 32'd3);
      repeat (2) @(negedge clk);

      // Address wrap from 31 to 0
      applyStimulus(1, 0, 8'h1F, 0, 8'h00);
      pushWr(5'd31, 16'hAB78);
      applyStimulus(0, 0, 8'hAB, 0, 8'h00);
      applyStimulus(0, 0, 8'h11, 0, 8'h00);
      pushWr(5'd1, 16'h2211);
      applyStimulus(0, 0, 8'h22, 0, 8'h00);

      // Reset in the middle of an odd-address data write
      applyStimulus(1, 0, 8'h03, 0, 8'h00);
      @(negedge clk);
      nWrite     = 1'b0;
      host_data  = 8'h55;
      host_drive = 1'b1;
      repeat (2) @(negedge clk);
      nDataStr = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("mid-reset nWait", {31'h0, nWait}, 32'h1);
      repeat (6) @(negedge clk);
      nDataStr = 1'b1;
      waitNWait(1'b1, "mid-reset release");
      @(negedge clk);
      host_drive = 1'b0;
      nWrite     = 1'b1;
      repeat (2) @(negedge clk);
      pushWr(5'd1, 16'h9900);
      applyStimulus(0, 0, 8'h99, 0, 8'h00);

      repeat (5) @(negedge clk);
      checkOutput("scoreboard drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
